icache: RTL and testbench

- Direct-mapped instruction cache sitting between the instruction fetcher and the memory controller's instruction port.
- Hits answer the fetcher combinationally in the same cycle.
- Misses drive the controller's ic_valid/ic_aout request, hold it until iout_ready, then fill one line with the returned 16-bit (compressed) or 32-bit instruction.
- Pending misses are aborted on pipeline flush.

---
 rtl/icache.sv | 111 +++++++++++
 tb/tb_icache.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetcher and the memory controller's instruction port.
// One instruction per line. Hits answer combinationally; a miss issues one request and fills a single line.
module icache #(
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        need_flush_in,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        hit_out,
  output logic [31:0] instr_out,
  output logic        is_compressed_out,
  output logic        ic_valid,
  output logic [31:0] ic_aout,
  input  logic        iout_ready,
  input  logic [31:0] mem_out
);

  localparam int unsigned LINES = 1 << INDEX_WIDTH;
  localparam int unsigned TAG_W = 31 - INDEX_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] comp_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [31:1]            miss_addr;
  logic [INDEX_WIDTH-1:0] lk_idx, fill_idx;
  logic [TAG_W-1:0]       lk_tag, fill_tag;
  logic                   launch, fill;
  logic                   fill_comp;
  logic [31:0]            fill_data;

  assign lk_idx   = if_pc[INDEX_WIDTH:1];
  assign lk_tag   = if_pc[31:INDEX_WIDTH+1];
  assign fill_idx = miss_addr[INDEX_WIDTH:1];
  assign fill_tag = miss_addr[31:INDEX_WIDTH+1];

  // Compressed instructions are stored zero-extended to 32 bits.
  assign fill_comp = (mem_out[1:0] != 2'b11);
  assign fill_data = fill_comp ? {16'b0, mem_out[15:0]} : mem_out;

  // Lookup reads only registered state, so a same-cycle fill is seen on the next cycle.
  assign hit_out           = if_valid && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign instr_out         = hit_out ? data_q[lk_idx] : 32'b0;
  assign is_compressed_out = hit_out && comp_q[lk_idx];

  // Request drops combinationally on the return pulse so the controller never re-fetches.
  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    fill     = 1'b0;
    ic_valid = (state_q == MISS) && !iout_ready;
    case (state_q)
      IDLE: begin
        if (rdy_in && if_valid && !hit_out && !need_flush_in) begin
          launch  = 1'b1;
          state_d = MISS;
        end
      end
      MISS: begin
        if (rdy_in) begin
          if (need_flush_in) begin
            state_d = IDLE;
          end else if (iout_ready) begin
            fill    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      ic_aout   <= 32'b0;
      miss_addr <= 31'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      if (launch) begin
        miss_addr <= if_pc[31:1];
        ic_aout   <= if_pc;
      end
      if (fill) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Payload arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_in) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
      comp_q[fill_idx] <= fill_comp;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a cycle-by-cycle vector table plus hand sequences for the busy and reset cases.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, need_flush_in, if_valid, iout_ready;
  logic [31:0] if_pc, mem_out;
  logic        hit_out, is_compressed_out, ic_valid;
  logic [31:0] instr_out, ic_aout;

  icache #(.INDEX_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .if_valid(if_valid), .if_pc(if_pc), .hit_out(hit_out), .instr_out(instr_out),
    .is_compressed_out(is_compressed_out), .ic_valid(ic_valid), .ic_aout(ic_aout),
    .iout_ready(iout_ready), .mem_out(mem_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, rdy, flush, ifv;
    logic [31:0] pc;
    logic        iord;
    logic [31:0] mem;
    logic        e_hit;
    logic        chk_instr;
    logic [31:0] e_instr;
    logic        e_comp;
    logic        e_icv;
    logic [31:0] e_aout;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic flush, input logic ifv,
                       input logic [31:0] pc, input logic iord, input logic [31:0] mem);
    rst_in = rst; rdy_in = rdy; need_flush_in = flush; if_valid = ifv;
    if_pc = pc; iout_ready = iord; mem_out = mem;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic rdy, input logic flush, input logic ifv,
                              input logic [31:0] pc, input logic iord, input logic [31:0] mem,
                              input logic e_hit, input logic chk_instr, input logic [31:0] e_instr,
                              input logic e_comp, input logic e_icv, input logic [31:0] e_aout);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.flush = flush; v.ifv = ifv; v.pc = pc; v.iord = iord; v.mem = mem;
    v.e_hit = e_hit; v.chk_instr = chk_instr; v.e_instr = e_instr; v.e_comp = e_comp;
    v.e_icv = e_icv; v.e_aout = e_aout;
    return v;
  endfunction

  initial begin
    // Fields: rst rdy flush ifv pc iord mem | hit chk instr comp icv aout
    vecs.push_back(mk(1,1,0,0,32'h0000_1000,0,32'h0,          0,1,32'h0,          0,0,32'h0));      // reset state
    vecs.push_back(mk(0,1,0,1,32'h0000_1000,0,32'h0,          0,0,32'h0,          0,0,32'h0));      // cold miss launches
    vecs.push_back(mk(0,1,0,1,32'h0000_1000,0,32'h0,          0,0,32'h0,          0,1,32'h1000));   // request visible
    vecs.push_back(mk(0,1,0,1,32'h0000_1000,1,32'h0051_0113,  0,0,32'h0,          0,0,32'h1000));   // return: icv drops, no hit yet
    vecs.push_back(mk(0,1,0,1,32'h0000_1000,0,32'h0,          1,1,32'h0051_0113,  0,0,32'h1000));   // hit next cycle
    vecs.push_back(mk(0,1,0,1,32'h0000_1002,0,32'h0,          0,0,32'h0,          0,0,32'h1000));   // compressed miss
    vecs.push_back(mk(0,1,0,1,32'h0000_1002,0,32'h0,          0,0,32'h0,          0,1,32'h1002));
    vecs.push_back(mk(0,1,0,1,32'h0000_1002,1,32'hABCD_4501,  0,0,32'h0,          0,0,32'h1002));
    vecs.push_back(mk(0,1,0,1,32'h0000_1002,0,32'h0,          1,1,32'h0000_4501,  1,0,32'h1002));   // zero-extended
    vecs.push_back(mk(0,1,0,1,32'h0000_1000,0,32'h0,          1,1,32'h0051_0113,  0,0,32'h1002));   // neighbour line intact
    vecs.push_back(mk(0,1,0,1,32'h0000_1020,0,32'h0,          0,0,32'h0,          0,0,32'h1002));   // conflict miss
    vecs.push_back(mk(0,1,0,1,32'h0000_1020,0,32'h0,          0,0,32'h0,          0,1,32'h1020));
    vecs.push_back(mk(0,1,0,1,32'h0000_1020,1,32'h0000_0013,  0,0,32'h0,          0,0,32'h1020));
    vecs.push_back(mk(0,1,0,1,32'h0000_1020,0,32'h0,          1,1,32'h0000_0013,  0,0,32'h1020));
    vecs.push_back(mk(0,1,0,1,32'h0000_1000,0,32'h0,          0,0,32'h0,          0,0,32'h1020));   // evicted
    vecs.push_back(mk(0,1,0,1,32'h0000_1000,0,32'h0,          0,0,32'h0,          0,1,32'h1000));   // re-request
    vecs.push_back(mk(0,1,0,1,32'h0000_1000,1,32'h0051_0113,  0,0,32'h0,          0,0,32'h1000));
    vecs.push_back(mk(0,1,0,1,32'h0000_1000,0,32'h0,          1,1,32'h0051_0113,  0,0,32'h1000));
    vecs.push_back(mk(0,1,0,0,32'h0000_1000,0,32'h0,          0,0,32'h0,          0,0,32'h1000));   // if_valid low: no hit
    vecs.push_back(mk(0,0,0,1,32'h0000_3000,0,32'h0,          0,0,32'h0,          0,0,32'h1000));   // rdy low: no launch
    vecs.push_back(mk(0,1,1,1,32'h0000_3000,0,32'h0,          0,0,32'h0,          0,0,32'h1000));   // flush in IDLE: no launch
    vecs.push_back(mk(0,1,0,0,32'h0000_3000,0,32'h0,          0,0,32'h0,          0,0,32'h1000));   // still IDLE
    vecs.push_back(mk(0,1,1,1,32'h0000_1000,0,32'h0,          1,1,32'h0051_0113,  0,0,32'h1000));   // hit reported during flush
    vecs.push_back(mk(0,1,0,1,32'h0000_2000,0,32'h0,          0,0,32'h0,          0,0,32'h1000));   // miss 0x2000
    vecs.push_back(mk(0,1,0,1,32'h0000_2000,0,32'h0,          0,0,32'h0,          0,1,32'h2000));
    vecs.push_back(mk(0,1,1,1,32'h0000_2000,1,32'h1111_1111,  0,0,32'h0,          0,0,32'h2000));   // flush + return: no fill
    vecs.push_back(mk(0,1,0,1,32'h0000_2000,0,32'h0,          0,0,32'h0,          0,0,32'h2000));   // IDLE, misses again
    vecs.push_back(mk(0,1,0,1,32'h0000_2000,0,32'h0,          0,0,32'h0,          0,1,32'h2000));   // new request
    vecs.push_back(mk(0,0,0,1,32'h0000_2000,1,32'h2222_2222,  0,0,32'h0,          0,0,32'h2000));   // rdy low: pulse ignored
    vecs.push_back(mk(0,1,0,1,32'h0000_2000,0,32'h0,          0,0,32'h0,          0,1,32'h2000));   // still MISS

    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    tick();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].flush, vecs[i].ifv, vecs[i].pc, vecs[i].iord, vecs[i].mem);
      #2;
      check($sformatf("v%0d.hit", i),  32'(hit_out),  32'(vecs[i].e_hit));
      check($sformatf("v%0d.icv", i),  32'(ic_valid), 32'(vecs[i].e_icv));
      check($sformatf("v%0d.aout", i), ic_aout,       vecs[i].e_aout);
      if (vecs[i].chk_instr) begin
        check($sformatf("v%0d.instr", i), instr_out,             vecs[i].e_instr);
        check($sformatf("v%0d.comp", i),  32'(is_compressed_out), 32'(vecs[i].e_comp));
      end
      tick();
    end

    // Controller busy for 20 cycles; a pc change must not redirect the pending miss.
    for (int c = 0; c < 20; c++) begin
      drive(0, 1, 0, 1, (c < 10) ? 32'h0000_2000 : 32'h0000_3000, 0, 32'h0);
      #2;
      check($sformatf("busy%0d.icv", c),  32'(ic_valid), 32'd1);
      check($sformatf("busy%0d.aout", c), ic_aout,       32'h0000_2000);
      tick();
    end
    drive(0, 1, 0, 1, 32'h0000_3000, 1, 32'h0000_0001);
    #2;
    check("busy.ret_icv", 32'(ic_valid), 32'd0);
    tick();
    drive(0, 1, 0, 1, 32'h0000_2000, 0, 32'h0);
    #2;
    check("busy.hit",   32'(hit_out),           32'd1);
    check("busy.instr", instr_out,              32'h0000_0001);
    check("busy.comp",  32'(is_compressed_out), 32'd1);
    tick();

    // 0x3000 shares line 0 with 0x2000: launch a miss, then reset in the middle of it.
    drive(0, 1, 0, 1, 32'h0000_3000, 0, 32'h0);
    #2;
    check("rm.prehit", 32'(hit_out), 32'd0);
    tick();
    drive(0, 1, 0, 1, 32'h0000_3000, 0, 32'h0);
    #2;
    check("rm.icv", 32'(ic_valid), 32'd1);
    check("rm.aout", ic_aout, 32'h0000_3000);
    tick();
    drive(1, 1, 0, 0, 32'h0000_3000, 0, 32'h0);
    tick();
    drive(0, 1, 0, 0, 32'h0000_3000, 1, 32'h0000_0013);
    #2;
    check("rm.stray_icv", 32'(ic_valid), 32'd0);
    check("rm.aout_rst",  ic_aout,       32'h0);
    tick();
    drive(0, 1, 0, 1, 32'h0000_3000, 0, 32'h0);
    #2;
    check("rm.hit3000", 32'(hit_out), 32'd0);
    tick();
    drive(0, 1, 0, 1, 32'h0000_2000, 0, 32'h0);
    #2;
    check("rm.hit2000", 32'(hit_out), 32'd0);
    check("rm.icv_new", 32'(ic_valid), 32'd1);
    check("rm.aout_new", ic_aout, 32'h0000_3000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
